bcd_to_binary: RTL and testbench

Sequential BCD-to-binary converter. It is the reverse path of the team's binary-to-BCD display converter and turns packed decimal operands (keypad or host entry) into binary values for the accelerator datapath. It converts one BCD digit per clock using an accumulate-times-ten loop, most-significant digit first, under a start/done handshake. It also flags non-decimal digits and results that do not fit the output width.

---
 rtl/bcd_to_binary.sv | 135 +++++++++++++
 tb/tb_bcd_to_binary.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first,
// accumulate-times-ten, with start/done handshake plus digit-error and overflow flags.
module bcd_to_binary #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        binary_out,
  output logic                    error,
  output logic                    overflow
);

  localparam int DIG_W = 4 * NUM_DIGITS;
  localparam int ACC_W = BIN_W + 4;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_flag_q, err_flag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               error_q, error_d;
  logic               ovf_q, ovf_d;
  logic               bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    dig_d      = dig_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bin_d      = bin_q;
    error_d    = error_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dig_d      = bcd_in;
          acc_d      = '0;
          cnt_d      = '0;
          err_flag_d = bad_digit;
          busy_d     = 1'b1;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        // acc*10 as shift-and-add; illegal digits still flow through and are discarded in FIN
        acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(dig_q[DIG_W-1 -: 4]);
        dig_d = dig_q << 4;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = S_FIN;
      end
      S_FIN: begin
        error_d = err_flag_q;
        if (err_flag_q) begin
          bin_d = '0;
          ovf_d = 1'b0;
        end else begin
          bin_d = acc_q[BIN_W-1:0];
          ovf_d = |acc_q[ACC_W-1:BIN_W];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dig_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bin_q      <= '0;
      error_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dig_q      <= dig_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bin_q      <= bin_d;
      error_q    <= error_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign binary_out = bin_q;
  assign error      = error_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: default (BIN_W=14) and narrow (BIN_W=12) instances,
// directed vectors push expectations, negedge monitors pop and compare on done.
module tb_bcd_to_binary;

  localparam int ND = 4;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [15:0] bcd_a, bcd_b;
  logic        busy_a, done_a, error_a, overflow_a;
  logic        busy_b, done_b, error_b, overflow_b;
  logic [13:0] bin_a;
  logic [11:0] bin_b;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  bcd_to_binary #(.NUM_DIGITS(ND), .BIN_W(14)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bcd_in(bcd_a),
    .busy(busy_a), .done(done_a), .binary_out(bin_a),
    .error(error_a), .overflow(overflow_a)
  );

  bcd_to_binary #(.NUM_DIGITS(ND), .BIN_W(12)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bcd_in(bcd_b),
    .busy(busy_b), .done(done_b), .binary_out(bin_b),
    .error(error_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare everything the DUT presents on a done pulse.
  always @(negedge clk) begin
    if (!rst && done_a) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_binary_out", bin_a, e.bin);
        check("a_error", error_a, e.err);
        check("a_overflow", overflow_a, e.ovf);
        check("a_done_cycle", cyc, e.cyc);
        check("a_busy_at_done", busy_a, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_binary_out", bin_b, e.bin);
        check("b_error", error_b, e.err);
        check("b_overflow", overflow_b, e.ovf);
        check("b_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge: the next posedge captures, done is seen ND+1 edges later.
  task automatic issue_a(input logic [15:0] v, input logic [13:0] bin, input logic err,
                         input logic ovf);
    exp_t e;
    @(negedge clk);
    bcd_a   = v;
    start_a = 1'b1;
    e.bin = bin; e.err = err; e.ovf = ovf; e.cyc = cyc + 1 + ND + 1;
    qa.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    bcd_a   = 16'hFFFF;
  endtask

  task automatic issue_b(input logic [15:0] v, input logic [13:0] bin, input logic err,
                         input logic ovf);
    exp_t e;
    @(negedge clk);
    bcd_b   = v;
    start_b = 1'b1;
    e.bin = bin; e.err = err; e.ovf = ovf; e.cyc = cyc + 1 + ND + 1;
    qb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    bcd_b   = 16'hFFFF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int cap;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bcd_a = '0; bcd_b = '0;
    idle(3);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_binary_out", bin_a, 0);
    check("rst_error", error_a, 0);
    check("rst_overflow", overflow_a, 0);
    rst = 1'b0;
    idle(2);

    // 4095 with busy-width measurement over the full conversion window
    issue_a(16'h4095, 14'd4095, 1'b0, 1'b0);
    busy_cnt = 0;
    repeat (7) begin
      if (busy_a) busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, 5);
    idle(2);

    issue_a(16'h9999, 14'd9999, 1'b0, 1'b0);
    idle(8);
    issue_a(16'h0000, 14'd0, 1'b0, 1'b0);
    idle(8);
    issue_a(16'h12A4, 14'd0, 1'b1, 1'b0);
    idle(8);
    issue_a(16'h0042, 14'd42, 1'b0, 1'b0);
    idle(8);

    // start pulsed mid-conversion must be dropped
    issue_a(16'h0123, 14'd123, 1'b0, 1'b0);
    bcd_a   = 16'h1111;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    idle(10);

    // start held: captures 7 cycles apart
    @(negedge clk);
    bcd_a   = 16'h0314;
    start_a = 1'b1;
    cap = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.bin = 14'd314; e.err = 1'b0; e.ovf = 1'b0; e.cyc = cap + ND + 1 + 7 * i;
      qa.push_back(e);
    end
    while (cyc < cap + 14) @(negedge clk);
    start_a = 1'b0;
    idle(12);

    // async reset during the second CONV cycle: no done, outputs cleared at once
    @(negedge clk);
    bcd_a   = 16'h5678;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_done", done_a, 0);
    check("arst_binary_out", bin_a, 0);
    check("arst_error", error_a, 0);
    check("arst_overflow", overflow_a, 0);
    idle(2);
    rst = 1'b0;
    idle(8);
    issue_a(16'h0007, 14'd7, 1'b0, 1'b0);
    idle(8);

    // narrow output: 9999 = 0x270F does not fit 12 bits
    issue_b(16'h9999, 14'h070F, 1'b0, 1'b1);
    idle(8);
    issue_b(16'h4095, 14'h0FFF, 1'b0, 1'b0);
    idle(10);

    check("a_pending", qa.size(), 0);
    check("b_pending", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
